// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with grant holding and an optional hold-time limit.
// Round-robin mode is built only when ARB_ROUND_ROBIN_EN is defined.
module priority_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int unsigned NU = N;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic            arb;
  logic [N-1:0]    arb_req;
  logic            holder_req;
  logic            expire;
  logic [IW-1:0]   win_idx;

  // Highest set index wins.
  function automatic logic [IW-1:0] fixed_pick(input logic [N-1:0] r);
    fixed_pick = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (r[i]) fixed_pick = IW'(i);
    end
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_idx_q, last_idx_d;

  // First set bit at or after last+1, ascending with wraparound.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [IW-1:0] last);
    int unsigned start, dist, best;
    start   = (32'(last) + 1) % NU;
    best    = NU;
    rr_pick = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (r[i]) begin
        dist = (i + NU - start) % NU;
        if (dist < best) begin
          best    = dist;
          rr_pick = IW'(i);
        end
      end
    end
  endfunction
`else
  logic unused_mode;
  always_comb unused_mode = mode;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    hold_cnt_d  = hold_cnt_q;
    arb         = 1'b0;
    arb_req     = req;
    holder_req  = |(req & gnt_q);
    expire      = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST);
`ifdef ARB_ROUND_ROBIN_EN
    last_idx_d  = last_idx_q;
`endif

    unique case (state_q)
      IDLE: arb = 1'b1;
      HOLD: begin
        if (!holder_req) begin
          arb = 1'b1;
        end else if (expire) begin
          // Expired holder is excluded from this one decision only.
          arb     = 1'b1;
          arb_req = req & ~gnt_q;
        end else if (MAX_HOLD > 0) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase

`ifdef ARB_ROUND_ROBIN_EN
    win_idx = mode ? rr_pick(arb_req, last_idx_q) : fixed_pick(arb_req);
`else
    win_idx = fixed_pick(arb_req);
`endif

    if (arb) begin
      hold_cnt_d = '0;
      if (|arb_req) begin
        state_d     = HOLD;
        gnt_valid_d = 1'b1;
        gnt_idx_d   = win_idx;
        for (int unsigned i = 0; i < NU; i++) gnt_d[i] = (IW'(i) == win_idx);
`ifdef ARB_ROUND_ROBIN_EN
        last_idx_d  = win_idx;
`endif
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      hold_cnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_idx_q  <= IW'(N - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_idx_q  <= last_idx_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: default 4-way, 4-way with MAX_HOLD=3, and 8-way.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_a, req_h;
  logic [7:0] req_8;
  logic       mode_a;
  logic       mode_off = 1'b0;

  logic [3:0] g_a, g_h;
  logic       gv_a, gv_h, gv_8;
  logic [1:0] gi_a, gi_h;
  logic [7:0] g_8;
  logic [2:0] gi_8;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  priority_arbiter #(.N(4), .MAX_HOLD(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .mode(mode_a),
    .gnt(g_a), .gnt_valid(gv_a), .gnt_idx(gi_a));

  priority_arbiter #(.N(4), .MAX_HOLD(3)) dut_h (
    .clk(clk), .reset_n(reset_n), .req(req_h), .mode(mode_off),
    .gnt(g_h), .gnt_valid(gv_h), .gnt_idx(gi_h));

  priority_arbiter #(.N(8), .MAX_HOLD(0)) dut_8 (
    .clk(clk), .reset_n(reset_n), .req(req_8), .mode(mode_off),
    .gnt(g_8), .gnt_valid(gv_8), .gnt_idx(gi_8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_a = 4'b1111; req_h = 4'b0000; req_8 = 8'h00; mode_a = 1'b0;
    step(); step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b0_00_0000) begin
      $display("FAIL reset_hold got v=%b idx=%0d gnt=%b exp v=0 idx=0 gnt=0000", gv_a, gi_a, g_a);
      miscompares++;
    end
    vectors++;
    if ({gv_8, gi_8, g_8} !== 12'h000) begin
      $display("FAIL reset_hold_n8 got v=%b idx=%0d gnt=%b exp all zero", gv_8, gi_8, g_8);
      miscompares++;
    end
    reset_n = 1'b1;
    step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b1_11_1000) begin
      $display("FAIL reset_release got v=%b idx=%0d gnt=%b exp v=1 idx=3 gnt=1000", gv_a, gi_a, g_a);
      miscompares++;
    end
  endtask

  task automatic test_fixed_hold();
    req_a = 4'b0011; step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b1_01_0010) begin
      $display("FAIL fixed_release got v=%b idx=%0d gnt=%b exp v=1 idx=1 gnt=0010", gv_a, gi_a, g_a);
      miscompares++;
    end
    req_a = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({gv_a, gi_a, g_a} !== 7'b1_01_0010) begin
        $display("FAIL fixed_hold[%0d] got v=%b idx=%0d gnt=%b exp v=1 idx=1 gnt=0010", i, gv_a, gi_a, g_a);
        miscompares++;
      end
    end
    req_a = 4'b1001; step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b1_11_1000) begin
      $display("FAIL fixed_handover got v=%b idx=%0d gnt=%b exp v=1 idx=3 gnt=1000", gv_a, gi_a, g_a);
      miscompares++;
    end
    req_a = 4'b0000; step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b0_00_0000) begin
      $display("FAIL fixed_to_idle got v=%b idx=%0d gnt=%b exp v=0 idx=0 gnt=0000", gv_a, gi_a, g_a);
      miscompares++;
    end
  endtask

  task automatic test_idle_n8();
    req_8 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (gv_8 !== 1'b0 || g_8 !== 8'h00) begin
        $display("FAIL n8_idle[%0d] got v=%b gnt=%b exp v=0 gnt=00000000", i, gv_8, g_8);
        miscompares++;
      end
    end
    req_8 = 8'b0101_0000; step();
    vectors++;
    if ({gv_8, gi_8, g_8} !== {1'b1, 3'd6, 8'b0100_0000}) begin
      $display("FAIL n8_grant got v=%b idx=%0d gnt=%b exp v=1 idx=6 gnt=01000000", gv_8, gi_8, g_8);
      miscompares++;
    end
    req_8 = 8'b0000_0001; step();
    vectors++;
    if ({gv_8, gi_8, g_8} !== {1'b1, 3'd0, 8'b0000_0001}) begin
      $display("FAIL n8_handover got v=%b idx=%0d gnt=%b exp v=1 idx=0 gnt=00000001", gv_8, gi_8, g_8);
      miscompares++;
    end
  endtask

  task automatic test_hold_expiry();
    logic [3:0] exp_a [5];
    logic [3:0] exp_b [7];
    exp_a = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    exp_b = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    req_h = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (g_h !== exp_a[i] || gv_h !== (|exp_a[i])) begin
        $display("FAIL expiry_solo[%0d] got v=%b gnt=%b exp gnt=%b", i, gv_h, g_h, exp_a[i]);
        miscompares++;
      end
    end
    req_h = 4'b0000; step();
    vectors++;
    if ({gv_h, gi_h, g_h} !== 7'b0_00_0000) begin
      $display("FAIL expiry_idle got v=%b idx=%0d gnt=%b exp all zero", gv_h, gi_h, g_h);
      miscompares++;
    end
    req_h = 4'b1001;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (g_h !== exp_b[i] || gv_h !== 1'b1) begin
        $display("FAIL expiry_pair[%0d] got v=%b gnt=%b exp gnt=%b", i, gv_h, g_h, exp_b[i]);
        miscompares++;
      end
    end
    req_h = 4'b0000;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [3:0] req_seq [5];
    logic [3:0] exp_g   [5];
    logic [1:0] exp_i   [5];
    req_seq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset_n = 1'b0; req_a = 4'b0000; step();
    reset_n = 1'b1; mode_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_a = req_seq[i];
      step();
      vectors++;
      if (g_a !== exp_g[i] || gi_a !== exp_i[i] || gv_a !== 1'b1) begin
        $display("FAIL rr_rotate[%0d] got v=%b idx=%0d gnt=%b exp idx=%0d gnt=%b", i, gv_a, gi_a, g_a, exp_i[i], exp_g[i]);
        miscompares++;
      end
    end
    mode_a = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_hold();
    logic [6:0] exp_after;
`ifdef ARB_ROUND_ROBIN_EN
    exp_after = 7'b1_00_0001;
`else
    exp_after = 7'b1_11_1000;
`endif
    req_a = 4'b1111; step();
    vectors++;
    if (gv_a !== 1'b1) begin
      $display("FAIL mid_hold_setup got v=%b exp v=1", gv_a);
      miscompares++;
    end
    reset_n = 1'b0; step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== 7'b0_00_0000) begin
      $display("FAIL mid_hold_reset got v=%b idx=%0d gnt=%b exp all zero", gv_a, gi_a, g_a);
      miscompares++;
    end
    reset_n = 1'b1; mode_a = 1'b1; step();
    vectors++;
    if ({gv_a, gi_a, g_a} !== exp_after) begin
      $display("FAIL mid_hold_after got v=%b idx=%0d gnt=%b exp %b", gv_a, gi_a, g_a, exp_after);
      miscompares++;
    end
    mode_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_hold();
    test_idle_n8();
    test_hold_expiry();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
